zld_b: RTL and testbench
========================

ZLD_B -- requirements
Module: zld_B

Interface
REQ-001 SHALL have parameter Wi, default 8: width of the encoded input token.
REQ-002 SHALL have parameter Wo, default 7: width of the decoded output data (Wo = Wi-1).
REQ-003 SHALL have parameter Wc, default 8: width of the run counter, sized to hold 128.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_d, input, Wi bits: encoded token from the zero run-length encoder.
REQ-007 SHALL have port i_v, input, 1 bit: i_d valid.
REQ-008 SHALL have port i_b, output, 1 bit: backpressure to upstream; 1 = do not present a new token.
REQ-009 SHALL have port o_d, output, Wo bits: decoded data.
REQ-010 SHALL have port o_v, output, 1 bit: o_d valid.
REQ-011 SHALL have port o_b, input, 1 bit: backpressure from downstream.
REQ-012 SHALL have no EOS ports and no EOS handling.

Function
REQ-013 SHALL treat an input transfer as occurring in a cycle with i_v=1 and i_b=0, and an output transfer as occurring in a cycle with o_v=1 and o_b=0.
REQ-014 SHALL decode token bit Wi-1 = 0 as a literal: emit one word o_d = i_d[Wo-1:0].
REQ-015 SHALL decode token bit Wi-1 = 1 as a zero run: emit N = i_d[Wo-1:0]+1 words of value 0, so N ranges 1..128.
REQ-016 SHALL hold o_d/o_v in a single output register, with out_ready = !o_v | !o_b.
REQ-017 SHALL implement FSM state IDLE: i_b = o_v & o_b.
REQ-018 SHALL implement FSM state RUN: i_b = 1.
REQ-019 SHALL, in IDLE with out_ready and a literal accepted, load o_d=literal, o_v=1, and remain in IDLE.
REQ-020 SHALL, in IDLE with out_ready and a run accepted, load o_d=0, o_v=1, cnt=N-1, and go to RUN if N>1, else stay in IDLE.
REQ-021 SHALL, in IDLE with out_ready and no input transfer, clear o_v.
REQ-022 SHALL, in IDLE with !out_ready, hold all state and o_d/o_v unchanged.
REQ-023 SHALL, in RUN with out_ready, load o_d=0, o_v=1, cnt=cnt-1, and return to IDLE when cnt was 1.
REQ-024 SHALL, in RUN with !out_ready, hold all state.
REQ-025 SHALL have latency of exactly one cycle from input transfer to the first corresponding o_v=1.
REQ-026 SHALL sustain one output word per cycle while o_b=0, including back-to-back tokens and a token accepted in the same cycle the last zero of a run is loaded.
REQ-027 SHALL keep o_d stable while o_v=1 and o_b=1.
REQ-028 SHALL generate i_b combinationally from state and o_v/o_b only, with no combinational path from i_v or i_d.
REQ-029 SHALL NOT treat literal value 0 as special; it emits a single zero word.

Reset
REQ-030 SHALL, while reset is asserted, asynchronously force o_v=0, o_d=0, cnt=0, state=IDLE, and therefore i_b=0 once o_v=0.
REQ-031 SHALL, on reset asserted mid-run, discard the remaining zeros; the first post-reset token decodes normally.

Structure
REQ-032 SHALL take Wi, Wo, the flag bit position (Wi-1), and the FSM state encodings IDLE/RUN from shared package zle_pkg, used by both the encoder and decoder.
REQ-033 SHALL be a single module with no sub-modules, instantiable between Q2 queues in a zld_BQ2 wrapper mirroring the encoder's.

Verification
REQ-034 SHALL cover: reset, then literals 0x05, 0x7F, 0x00 back-to-back with o_b=0 -> o_d = 05, 7F, 00 on consecutive cycles, first one cycle after acceptance, i_b=0 throughout.
REQ-035 SHALL cover: token 0x83 then literal 0x11, o_b=0 -> four 0x00 words then 0x11, contiguous; i_b=1 for the 3 cycles in RUN.
REQ-036 SHALL cover: tokens 0x80 and 0xFF -> one 0x00 word (no RUN entry) and 128 0x00 words respectively.
REQ-037 SHALL cover: token 0x82 with o_b toggled 1,0,1,1,0,0 -> exactly three 0x00 transfers, o_d/o_v held during stalls, i_b=1 until the last zero is loaded.
REQ-038 SHALL cover: reset asserted after 10 of 100 zeros from token 0xE3 -> o_v=0 immediately, state=IDLE; next token 0x2A -> single output 0x2A.
REQ-039 SHALL cover: random literal/run tokens through zle_B then zld_B, with random i_v/o_b -> output stream identical to the encoder input stream.

Source files
------------

// File: rtl/zle_pkg.sv
// Shared definitions for the zero run-length encoder/decoder pair:
// token geometry and FSM state encodings.
package zle_pkg;

  localparam int ZLE_WI = 8;
  localparam int ZLE_WO = ZLE_WI - 1;
  localparam int ZLE_WC = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } zle_state_e;

  // The MSB of a token selects literal (0) versus zero run (1).
  function automatic int zle_flag_pos(input int wi);
    return wi - 1;
  endfunction

endpackage

// File: rtl/zld_b.sv
// Zero run-length decoder: literal tokens pass through, run tokens expand
// into N = payload+1 zero words, one output word per cycle.
module zld_b
  import zle_pkg::*;
#(
  parameter int Wi = ZLE_WI,
  parameter int Wo = ZLE_WO,
  parameter int Wc = ZLE_WC
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [Wi-1:0] i_d,
  input  logic          i_v,
  output logic          i_b,
  output logic [Wo-1:0] o_d,
  output logic          o_v,
  input  logic          o_b
);

  localparam int FlagBit = zle_flag_pos(Wi);

  zle_state_e    state_q, state_d;
  logic [Wc-1:0] cnt_q, cnt_d;
  logic [Wo-1:0] o_d_q, o_d_d;
  logic          o_v_q, o_v_d;
  logic          out_ready;
  logic          in_xfer;

  // Upstream stall depends only on registered state and o_b.
  assign out_ready = !o_v_q || !o_b;
  assign i_b       = (state_q == RUN) || (o_v_q && o_b);
  assign in_xfer   = i_v && !i_b;

  assign o_d = o_d_q;
  assign o_v = o_v_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d_d   = o_d_q;
    o_v_d   = o_v_q;
    case (state_q)
      IDLE: begin
        if (out_ready) begin
          if (in_xfer) begin
            o_v_d = 1'b1;
            if (!i_d[FlagBit]) begin
              o_d_d = i_d[Wo-1:0];
            end else begin
              o_d_d = '0;
              cnt_d = Wc'(i_d[Wo-1:0]);
              if (i_d[Wo-1:0] != '0) begin
                state_d = RUN;
              end
            end
          end else begin
            o_v_d = 1'b0;
          end
        end
      end
      RUN: begin
        // cnt holds the zeros still to be loaded after the current one.
        if (out_ready) begin
          o_d_d = '0;
          o_v_d = 1'b1;
          cnt_d = cnt_q - Wc'(1);
          if (cnt_q == Wc'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_d_q   <= '0;
      o_v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_d_q   <= o_d_d;
      o_v_q   <= o_v_d;
    end
  end

endmodule

// File: tb/tb_zld_b.sv
// Directed and random checks of zld_b against a token-expansion scoreboard.
module tb_zld_b;

  logic       clock;
  logic       reset;
  logic [7:0] i_d;
  logic       i_v;
  logic       i_b;
  logic [6:0] o_d;
  logic       o_v;
  logic       o_b;

  int         total;
  int         bad;
  int         xfer_count;
  logic       rand_ob_en;
  logic [6:0] sb[$];

  zld_b dut (
    .clock(clock),
    .reset(reset),
    .i_d  (i_d),
    .i_v  (i_v),
    .i_b  (i_b),
    .o_d  (o_d),
    .o_v  (o_v),
    .o_b  (o_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (rand_ob_en) o_b = ($urandom_range(0, 3) == 0);
  end

  // Every output transfer is matched against the oldest expected word.
  always @(negedge clock) begin
    logic [6:0] exp_w;
    if (!reset && o_v && !o_b) begin
      xfer_count++;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("[TB] FAIL sb_underflow observed=%0d words expected>0", sb.size());
      end
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        total++;
        assert (o_d === exp_w) else begin
          bad++;
          $error("[TB] FAIL o_d observed=%0h expected=%0h", o_d, exp_w);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_expected(input logic [7:0] tok);
    if (!tok[7]) begin
      sb.push_back(tok[6:0]);
    end else begin
      for (int k = 0; k <= int'(tok[6:0]); k++) sb.push_back(7'h00);
    end
  endtask

  // Presents a token until accepted; returns the number of stalled cycles.
  task automatic send_token(input logic [7:0] tok, output int waits);
    i_d   = tok;
    i_v   = 1'b1;
    waits = 0;
    @(negedge clock);
    while (i_b && waits < 1000) begin
      waits++;
      @(negedge clock);
    end
    check("accept_timeout", waits < 1000, 1);
    if (!i_b) push_expected(tok);
    @(posedge clock);
    #1;
    i_v = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int         w;
    int         x0;
    int         cyc;
    logic [5:0] ob_pat;
    logic [5:0] ib_exp;
    logic [7:0] tok;

    clock      = 1'b0;
    reset      = 1'b1;
    i_d        = 8'h00;
    i_v        = 1'b0;
    o_b        = 1'b1;
    rand_ob_en = 1'b0;
    total      = 0;
    bad        = 0;
    xfer_count = 0;

    idle_cycles(2);
    check("rst_o_v", o_v, 0);
    check("rst_o_d", o_d, 0);
    check("rst_i_b", i_b, 0);
    reset = 1'b0;
    o_b   = 1'b0;
    idle_cycles(1);

    $display("[TB] back-to-back literals");
    send_token(8'h05, w);
    check("lit05_o_v", o_v, 1);
    check("lit05_o_d", o_d, 7'h05);
    check("lit05_i_b", i_b, 0);
    send_token(8'h7F, w);
    check("lit7f_o_d", o_d, 7'h7F);
    check("lit7f_wait", w, 0);
    send_token(8'h00, w);
    check("lit00_o_d", o_d, 7'h00);
    check("lit00_o_v", o_v, 1);
    check("lit00_wait", w, 0);

    $display("[TB] run of four then literal");
    send_token(8'h83, w);
    check("run4_i_b", i_b, 1);
    send_token(8'h11, w);
    check("run4_stall", w, 3);
    check("run4_next_o_d", o_d, 7'h11);

    $display("[TB] single-zero and maximal runs");
    send_token(8'h80, w);
    check("run1_i_b", i_b, 0);
    check("run1_o_v", o_v, 1);
    send_token(8'hFF, w);
    send_token(8'h01, w);
    check("run128_stall", w, 127);
    check("run128_next_o_d", o_d, 7'h01);
    idle_cycles(2);
    check("drain_o_v", o_v, 0);

    $display("[TB] run of three under backpressure");
    send_token(8'h82, w);
    x0     = xfer_count;
    ob_pat = 6'b001101;
    ib_exp = 6'b011111;
    for (int k = 0; k < 6; k++) begin
      o_b = ob_pat[k];
      @(negedge clock);
      check($sformatf("stall_i_b_%0d", k), i_b, ib_exp[k]);
      check($sformatf("stall_o_v_%0d", k), o_v, 1);
      @(posedge clock);
      #1;
    end
    o_b = 1'b0;
    check("stall_xfers", xfer_count - x0, 3);
    check("stall_end_o_v", o_v, 0);

    $display("[TB] reset in the middle of a run");
    send_token(8'hE3, w);
    x0  = xfer_count;
    cyc = 0;
    while (xfer_count - x0 < 10 && cyc < 500) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("midrun_reached", xfer_count - x0, 10);
    reset = 1'b1;
    #1;
    check("midrun_rst_o_v", o_v, 0);
    check("midrun_rst_i_b", i_b, 0);
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    x0    = xfer_count;
    send_token(8'h2A, w);
    check("post_rst_wait", w, 0);
    check("post_rst_o_d", o_d, 7'h2A);
    idle_cycles(3);
    check("post_rst_xfers", xfer_count - x0, 1);
    check("post_rst_o_v", o_v, 0);

    $display("[TB] random tokens with random backpressure");
    rand_ob_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    tok = {1'b1, 7'($urandom_range(0, 15))};
        2:       tok = {1'b1, 7'($urandom_range(0, 127))};
        default: tok = {1'b0, 7'($urandom_range(0, 127))};
      endcase
      send_token(tok, w);
      idle_cycles($urandom_range(0, 2));
    end
    rand_ob_en = 1'b0;
    @(posedge clock);
    #2;
    o_b = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 2000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("rand_drained", sb.size(), 0);
    idle_cycles(2);
    check("rand_end_o_v", o_v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
